ram_access_sequencer: RTL and testbench
=======================================

Name: ram_access_sequencer

Overview:
- Initiator side of the ram strobe interface: converts a single-beat read/write request into the ordered sa -> s/e strobe sequence that the ram block expects.
- Drives the ram's address, set-address, set, enable and data-in pins, and returns read data.
- Sits between the processor control step logic (or any bus user) and the ram instance.
- One access in flight at a time; strobes are mutually exclusive and separated by programmable gaps.

Parameters:
- ADDR_W, 8, width of the ram address bus.
- DATA_W, 8, width of the ram data buses.
- STROBE_CYCLES, 1, clock cycles each strobe (sa, s, e) is held high; legal range >= 1.
- GAP_CYCLES, 1, idle cycles after each strobe with all strobes low; legal range >= 0, where 0 skips the gap states.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request this cycle.
- req_we  in  1  1 = write (s strobe), 0 = read (e strobe).
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse: access complete.
- rsp_rdata  out  DATA_W  read data from the last completed read.
- busy  out  1  high whenever state != IDLE.
- ram_a  out  ADDR_W  to ram a.
- ram_sa  out  1  to ram sa.
- ram_s  out  1  to ram s.
- ram_e  out  1  to ram e.
- ram_d_in  out  DATA_W  to ram d_in.
- ram_d_out  in  DATA_W  from ram d_out.

Behaviour:
- Reset values (asynchronous, immediate):
  - state = IDLE.
  - req_ready = 1 once reset releases.
  - rsp_valid, busy, ram_sa, ram_s, ram_e = 0.
  - ram_a, ram_d_in, rsp_rdata = 0.
- Handshake:
  - Accept on a rising edge where req_valid && req_ready.
  - On accept, register addr/wdata/we into ram_a/ram_d_in/we_q.
  - req_ready = 1 only in IDLE.
- States and transitions (a phase counter counts each phase length):
  - IDLE -> ADDR on accept.
  - ADDR: ram_sa = 1 for STROBE_CYCLES, then ADDR_GAP (or DATA if GAP_CYCLES = 0).
  - ADDR_GAP: all strobes low for GAP_CYCLES, then DATA.
  - DATA: ram_s = we_q, ram_e = !we_q, held for STROBE_CYCLES, then DATA_GAP (or DONE if GAP_CYCLES = 0).
  - DATA_GAP: all strobes low for GAP_CYCLES, then DONE.
  - DONE: rsp_valid = 1 for exactly one cycle, then IDLE.
- Latency: rsp_valid rises 2*(STROBE_CYCLES+GAP_CYCLES) rising edges after the accept edge. With defaults this is 4 edges; the next accept is possible 6 edges after the previous one.
- Read capture: rsp_rdata <= ram_d_out on the edge that ends the final DATA cycle, while ram_e is still high. rsp_rdata then holds that value until the next read completes. Writes never modify rsp_rdata.
- Strobes are registered outputs, glitch-free, and never high simultaneously. The ram sees a strobe only after ram_a/ram_d_in have been stable for at least one cycle.
- ram_a and ram_d_in are held stable from the accept edge until the next accept; req_* changes while busy are ignored.
- Address wrap: none; ram_a passes req_addr unmodified (0xFF is legal).
- Reset mid-access: all strobes and rsp_valid drop immediately; the aborted access is never reported.
- req_valid held continuously: back-to-back accepts occur every 2*(STROBE_CYCLES+GAP_CYCLES)+2 cycles.

Decomposition:
- Package ram_seq_pkg:
  - state enumeration: IDLE, ADDR, ADDR_GAP, DATA, DATA_GAP, DONE.
  - default width constants.
  - localparam phase-counter width, clog2(max(STROBE_CYCLES, GAP_CYCLES)+1).
- Sub-module phase_timer:
  - loadable down-counter with a terminal-count flag.
  - the main block instantiates it once and reloads it at each state entry.

Test Plan:
- Write 8'hA5 to 8'h3C (defaults) -> ram_sa high 1 cycle, 1 low cycle, ram_s high 1 cycle, rsp_valid 4 edges after accept; ram e never asserted.
- Read 8'h3C after that write, using a behavioural ram model -> rsp_rdata = 8'hA5; ram_e high exactly 1 cycle; rsp_rdata unchanged by a subsequent write to 8'h10.
- Fill pass, as in the ram bench: write addr i with data 8'hFF-i for i = 0..255, then read all 256 -> every read returns 8'hFF-i, including i = 255 returning 8'h00.
- STROBE_CYCLES = 3, GAP_CYCLES = 0 -> ram_sa high 3 cycles immediately followed by ram_s/ram_e high 3 cycles, rsp_valid 6 edges after accept; strobes never overlap.
- Assert rst_n low during a write's DATA phase -> ram_s falls immediately without waiting for clk; no rsp_valid; after release req_ready = 1 and the next read returns the pre-reset ram contents.
- Change req_addr/req_wdata while busy with req_valid low -> ram_a/ram_d_in unchanged until the next accept; assertion check that at most one of ram_sa/ram_s/ram_e is high in any cycle.

Source files
------------

// File: rtl/ram_seq_pkg.sv
// ram_seq_pkg: shared types and width helpers for the ram strobe sequencer.
// Holds the FSM state enum, default widths and the phase-counter sizing.
package ram_seq_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 8;
  localparam int STROBE_DEF  = 1;
  localparam int GAP_DEF     = 1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_GAP,
    DATA,
    DATA_GAP,
    DONE
  } state_t;

  function automatic int phase_w(input int strobe, input int gap);
    int m;
    m = (strobe > gap) ? strobe : gap;
    return $clog2(m + 1);
  endfunction

  localparam int PHASE_W_DEF = phase_w(STROBE_DEF, GAP_DEF);

endpackage

// File: rtl/ram_access_sequencer_phase_timer.sv
// phase_timer: loadable down-counter, tc high while the count is zero.
// Ports: clk, rst_n, load, load_val -> tc.
module phase_timer
  import ram_seq_pkg::*;
#(
  parameter int W = PHASE_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/ram_access_sequencer.sv
// ram_access_sequencer: turns one read/write request into sa -> s/e strobes.
// Ports: req_* handshake in, rsp_valid/rsp_rdata/busy out, ram_* pins.
module ram_access_sequencer
  import ram_seq_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int STROBE_CYCLES = STROBE_DEF,
  parameter int GAP_CYCLES    = GAP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_sa,
  output logic              ram_s,
  output logic              ram_e,
  output logic [DATA_W-1:0] ram_d_in,
  input  logic [DATA_W-1:0] ram_d_out
);

  localparam int PW      = phase_w(STROBE_CYCLES, GAP_CYCLES);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);
  localparam int G_M1    = HAS_GAP ? GAP_CYCLES - 1 : 0;

  localparam logic [PW-1:0] S_LD = PW'(STROBE_CYCLES - 1);
  localparam logic [PW-1:0] G_LD = PW'(G_M1);

  state_t        state;
  logic          we_q;
  logic          accept;
  logic          tc;
  logic          t_load;
  logic [PW-1:0] t_val;

  assign accept = req_valid && req_ready;

  // Timer reloads on the same edge that enters each timed state.
  always_comb begin
    t_load = 1'b0;
    t_val  = S_LD;
    case (state)
      IDLE: t_load = accept;
      ADDR: begin
        if (tc) begin
          t_load = 1'b1;
          t_val  = HAS_GAP ? G_LD : S_LD;
        end
      end
      ADDR_GAP: t_load = tc;
      DATA: begin
        if (tc && HAS_GAP) begin
          t_load = 1'b1;
          t_val  = G_LD;
        end
      end
      default: t_load = 1'b0;
    endcase
  end

  phase_timer #(
    .W(PW)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (t_load),
    .load_val(t_val),
    .tc      (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      ram_sa    <= 1'b0;
      ram_s     <= 1'b0;
      ram_e     <= 1'b0;
      ram_a     <= '0;
      ram_d_in  <= '0;
      rsp_rdata <= '0;
      we_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ram_a     <= req_addr;
            ram_d_in  <= req_wdata;
            we_q      <= req_we;
            ram_sa    <= 1'b1;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (tc) begin
            ram_sa <= 1'b0;
            if (HAS_GAP) begin
              state <= ADDR_GAP;
            end else begin
              ram_s <= we_q;
              ram_e <= !we_q;
              state <= DATA;
            end
          end
        end
        ADDR_GAP: begin
          if (tc) begin
            ram_s <= we_q;
            ram_e <= !we_q;
            state <= DATA;
          end
        end
        DATA: begin
          if (tc) begin
            ram_s <= 1'b0;
            ram_e <= 1'b0;
            // ram_e is still high on this edge, so d_out is valid.
            if (!we_q) begin
              rsp_rdata <= ram_d_out;
            end
            if (HAS_GAP) begin
              state <= DATA_GAP;
            end else begin
              rsp_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DATA_GAP: begin
          if (tc) begin
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_sequencer.sv
// tb_ram_access_sequencer: scoreboard bench for the ram strobe sequencer.
// Two instances: defaults, and STROBE_CYCLES=3 / GAP_CYCLES=0.
module tb_ram_access_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [7:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic [7:0] ram_a;
  logic       ram_sa, ram_s, ram_e;
  logic [7:0] ram_d_in;
  logic [7:0] ram_d_out;

  logic       b_req_valid = 1'b0;
  logic       b_req_ready;
  logic       b_req_we = 1'b0;
  logic [7:0] b_req_addr = '0;
  logic [7:0] b_req_wdata = '0;
  logic       b_rsp_valid;
  logic [7:0] b_rsp_rdata;
  logic       b_busy;
  logic [7:0] b_ram_a;
  logic       b_ram_sa, b_ram_s, b_ram_e;
  logic [7:0] b_ram_d_in;
  logic [7:0] b_ram_d_out;

  ram_access_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .ram_a(ram_a), .ram_sa(ram_sa), .ram_s(ram_s), .ram_e(ram_e),
    .ram_d_in(ram_d_in), .ram_d_out(ram_d_out)
  );

  ram_access_sequencer #(
    .STROBE_CYCLES(3), .GAP_CYCLES(0)
  ) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .busy(b_busy),
    .ram_a(b_ram_a), .ram_sa(b_ram_sa), .ram_s(b_ram_s), .ram_e(b_ram_e),
    .ram_d_in(b_ram_d_in), .ram_d_out(b_ram_d_out)
  );

  // Behavioural ram: sa latches the address, s writes, d_out follows it.
  logic [7:0] mem [256];
  logic [7:0] maddr;
  always @(posedge clk) begin
    if (ram_sa) maddr <= ram_a;
    if (ram_s) mem[maddr] <= ram_d_in;
  end
  assign ram_d_out   = mem[maddr];
  assign b_ram_d_out = 8'h5A;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] rdata;
    int         acc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected none");
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_latency", cyc - e.acc, 4);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      assert ($onehot0({ram_sa, ram_s, ram_e}) &&
              $onehot0({b_ram_sa, b_ram_s, b_ram_e}))
      else begin
        errors++;
        $display("FAIL strobe_overlap: got %b/%b expected onehot0",
                 {ram_sa, ram_s, ram_e}, {b_ram_sa, b_ram_s, b_ram_e});
      end
    end
  end

  task automatic do_req(input logic we, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] exp,
                        output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
      acc = -1;
      return;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    acc = cyc;
    sb.push_back('{rdata: exp, acc: acc});
  endtask

  // pat nibble k = {sa,s,e,rsp_valid} at the k-th negedge after accept.
  task automatic chk_pat(input bit which, input int n,
                         input logic [31:0] pat, input string nm);
    logic [3:0] s;
    for (int k = 0; k < n; k++) begin
      s = which ? {b_ram_sa, b_ram_s, b_ram_e, b_rsp_valid}
                : {ram_sa, ram_s, ram_e, rsp_valid};
      chk(nm, s, pat[4*k +: 4]);
      @(negedge clk);
    end
  endtask

  initial begin
    int acc, prev, n;
    logic [7:0] last_rd, v;
    last_rd = 8'h00;
    prev = 0;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {ram_sa, ram_s, ram_e}, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ram_a", ram_a, 0);
    chk("rst_ram_d_in", ram_d_in, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);

    do_req(1'b1, 8'h3C, 8'hA5, last_rd, acc);
    chk("wr_ram_a", ram_a, 8'h3C);
    chk("wr_ram_d_in", ram_d_in, 8'hA5);
    chk_pat(1'b0, 5, 32'h0001_0408, "wr_strobe_seq");

    do_req(1'b0, 8'h3C, 8'h00, 8'hA5, acc);
    chk_pat(1'b0, 5, 32'h0001_0208, "rd_strobe_seq");
    last_rd = 8'hA5;

    do_req(1'b1, 8'h10, 8'h42, last_rd, acc);
    req_addr  = 8'hEE;
    req_wdata = 8'h77;
    for (int k = 0; k < 4; k++) begin
      chk("hold_ram_a", ram_a, 8'h10);
      chk("hold_ram_d_in", ram_d_in, 8'h42);
      @(negedge clk);
    end

    @(negedge clk);
    b_req_valid = 1'b1;
    b_req_we    = 1'b0;
    b_req_addr  = 8'h77;
    @(negedge clk);
    b_req_valid = 1'b0;
    chk("s3_ram_a", b_ram_a, 8'h77);
    chk_pat(1'b1, 7, 32'h0122_2888, "s3_strobe_seq");
    chk("s3_rsp_rdata", b_rsp_rdata, 8'h5A);

    for (int i = 0; i < 256; i++) begin
      v = 8'(255 - i);
      do_req(1'b1, 8'(i), v, last_rd, acc);
      if (i > 0 && i < 4) chk("b2b_spacing", acc - prev, 6);
      prev = acc;
    end
    for (int i = 0; i < 256; i++) begin
      v = 8'(255 - i);
      do_req(1'b0, 8'(i), 8'h00, v, acc);
      last_rd = v;
    end

    do_req(1'b1, 8'h20, 8'h11, last_rd, acc);
    do_req(1'b1, 8'h20, 8'h99, last_rd, acc);
    repeat (2) @(negedge clk);
    chk("abort_s_high", ram_s, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_s_low", ram_s, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    sb.delete();
    last_rd = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_req_ready", req_ready, 1);
    chk("abort_rsp_rdata", rsp_rdata, 0);
    do_req(1'b0, 8'h20, 8'h00, 8'h11, acc);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
